// File: rtl/seg_display_decoder.sv
// seg_display_decoder: two-beat active-low 7-seg stream (tens then ones) to a validated binary value on a valid/ready port, with error strobe/code
module seg_display_decoder #(
    parameter int MAX_VALUE = 99,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    input  logic       digit_sel,
    output logic [6:0] temp,
    output logic       temp_blank,
    output logic       temp_valid,
    input  logic       temp_ready,
    output logic       err_pulse,
    output logic [2:0] err_code
);
    typedef enum logic {WAIT_TENS, WAIT_ONES} state_t;
    localparam logic [2:0] E_NONE = 3'd0, E_BAD = 3'd1, E_SEQ = 3'd2, E_TMO = 3'd3, E_RNG = 3'd4, E_OVR = 3'd5;
    state_t state_q, state_d;
    logic [3:0] tens_q, tens_d, dig;
    logic blank_q, blank_d, dig_ok, blank, load;
    logic [15:0] timer_q, timer_d;
    logic [6:0] value;
    logic [2:0] err;
    always_comb begin
        dig_ok = 1'b1;
        dig = 4'd0;
        case (seg_in)
            7'b1000000: dig = 4'd0;
            7'b1111001: dig = 4'd1;
            7'b0100100: dig = 4'd2;
            7'b0110000: dig = 4'd3;
            7'b0011001: dig = 4'd4;
            7'b0010010: dig = 4'd5;
            7'b0000010: dig = 4'd6;
            7'b1111000: dig = 4'd7;
            7'b0000000: dig = 4'd8;
            7'b0010000: dig = 4'd9;
            default:    dig_ok = 1'b0;
        endcase
    end
    assign blank = seg_in == 7'b1111111;
    assign value = 7'(tens_q) * 7'd10 + 7'(dig);
    always_comb begin
        state_d = state_q;
        tens_d = tens_q;
        blank_d = blank_q;
        timer_d = timer_q;
        load = 1'b0;
        err = E_NONE;
        if (seg_valid && digit_sel) begin
            if (dig_ok || blank) begin
                tens_d = blank ? 4'd0 : dig;
                blank_d = blank;
                timer_d = 16'd0;
                state_d = WAIT_ONES;
                err = state_q == WAIT_ONES ? E_SEQ : E_NONE;
            end else begin
                err = E_BAD;
                state_d = WAIT_TENS;
            end
        end else if (seg_valid) begin
            state_d = WAIT_TENS;
            if (state_q == WAIT_TENS) err = E_SEQ;
            else if (!dig_ok) err = E_BAD;
            else if (32'(value) > MAX_VALUE) err = E_RNG;
            else if (!temp_valid || temp_ready) load = 1'b1;
            else err = E_OVR;
        end else if (state_q == WAIT_ONES) begin
            timer_d = timer_q + 16'd1;
            if (timer_q == 16'(TIMEOUT - 1)) begin
                err = E_TMO;
                state_d = WAIT_TENS;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_TENS;
            tens_q <= 4'd0;
            blank_q <= 1'b0;
            timer_q <= 16'd0;
            temp <= 7'd0;
            temp_blank <= 1'b0;
            temp_valid <= 1'b0;
            err_pulse <= 1'b0;
            err_code <= E_NONE;
        end else begin
            state_q <= state_d;
            tens_q <= tens_d;
            blank_q <= blank_d;
            timer_q <= timer_d;
            temp <= load ? value : temp;
            temp_blank <= load ? blank_q : temp_blank;
            temp_valid <= load || (temp_valid && !temp_ready);
            err_pulse <= err != E_NONE;
            err_code <= err != E_NONE ? err : err_code;
        end
    end
endmodule
